// File: rtl/spram2flash.sv
// spram2flash: copies SPRAM words 0 .. SIZE/2-1 into SPI flash.
// For each 4 KB sector it erases, polls, then writes 16 pages
// (write-enable, page-program, poll). Mode-0 SPI, 2 clk per bit.
module spram2flash #(
   parameter logic [23:0] SPI_SAVE_OFFSET = 24'h0A0000,
   parameter logic [23:0] SPI_SAVE_SIZE   = 24'h002000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        save_done,
   output logic [15:0] spram_addr,
   output logic        spram_cs,
   output logic        spram_we,
   input  logic [15:0] spram_d_read,
   output logic        spi_ss,
   output logic        spi_so,
   input  logic        spi_si,
   output logic        spi_sck
);

   typedef enum logic [2:0] {
      S_IDLE, S_WREN, S_ERASE, S_POLL, S_PROGRAM, S_GAP, S_DONE
   } state_t;

   localparam logic [11:0] LAST_SECTOR = 12'((SPI_SAVE_SIZE >> 12) - 24'd1);
   localparam logic [11:0] WREN_LAST   = 12'd7;
   localparam logic [11:0] HDR_LAST    = 12'd31;
   localparam logic [11:0] PROG_LAST   = 12'd2079;
   localparam logic [11:0] POLL_END    = 12'd15;
   localparam logic [11:0] POLL_WRAP   = 12'd8;
   localparam logic [2:0]  GAP_LAST    = 3'd4;

   state_t      state_q, state_d;
   state_t      ret_q, ret_d;          // frame state entered when GAP ends
   logic        frame_on_q, frame_on_d; // SS low, bits in flight
   logic        phase_q, phase_d;       // 0: SCK low half, 1: SCK high half
   logic        ss_q, ss_d;
   logic        sck_q, sck_d;
   logic        so_q, so_d;
   logic [30:0] tx_q, tx_d;             // header bits still to send
   logic [11:0] bit_cnt_q, bit_cnt_d;   // index of the bit on the wire
   logic [15:0] wsr_q, wsr_d;           // data word being shifted out
   logic [15:0] word_buf_q, word_buf_d; // prefetched SPRAM word
   logic        cs_q, cs_d;
   logic        cs_dly_q, cs_dly_d;     // read data arrives when this is high
   logic [15:0] spram_addr_q, spram_addr_d;
   logic [15:0] rd_addr_q, rd_addr_d;   // next SPRAM word to fetch
   logic [11:0] sector_q, sector_d;
   logic [3:0]  page_q, page_d;
   logic        erase_phase_q, erase_phase_d; // current WREN/POLL belongs to an erase
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [2:0]  gap_cnt_q, gap_cnt_d;

   logic [23:0] sector_addr;
   logic [23:0] page_addr;
   logic [31:0] header;
   logic        frame_last;
   logic [10:0] data_idx;
   logic [15:0] word_swapped;

   // Frame header, flash addresses and end-of-frame detection for the current state
   always_comb begin
      sector_addr  = SPI_SAVE_OFFSET + {sector_q, 12'h000};
      page_addr    = sector_addr + {12'h000, page_q, 8'h00};
      data_idx     = 11'(bit_cnt_q - HDR_LAST);
      // low byte goes out first, matching the loader's packing
      word_swapped = {word_buf_q[7:0], word_buf_q[15:8]};
      case (state_q)
         S_ERASE:   header = {8'h20, sector_addr};
         S_PROGRAM: header = {8'h02, page_addr};
         S_POLL:    header = {8'h05, 24'h000000};
         default:   header = {8'h06, 24'h000000};
      endcase
      case (state_q)
         S_WREN:    frame_last = (bit_cnt_q == WREN_LAST);
         S_ERASE:   frame_last = (bit_cnt_q == HDR_LAST);
         S_PROGRAM: frame_last = (bit_cnt_q == PROG_LAST);
         // bit_cnt 15 is status bit0 (WIP); stop on the first idle byte
         S_POLL:    frame_last = (bit_cnt_q == POLL_END) && !spi_si;
         default:   frame_last = 1'b0;
      endcase
   end

   // Next-state logic: sequencing, SPI bit engine and SPRAM prefetch
   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      frame_on_d    = frame_on_q;
      phase_d       = phase_q;
      ss_d          = ss_q;
      sck_d         = sck_q;
      so_d          = so_q;
      tx_d          = tx_q;
      bit_cnt_d     = bit_cnt_q;
      wsr_d         = wsr_q;
      word_buf_d    = word_buf_q;
      cs_d          = 1'b0;
      cs_dly_d      = cs_q;
      spram_addr_d  = spram_addr_q;
      rd_addr_d     = rd_addr_q;
      sector_d      = sector_q;
      page_d        = page_q;
      erase_phase_d = erase_phase_q;
      busy_d        = busy_q;
      done_d        = done_q;
      gap_cnt_d     = gap_cnt_q;

      if (cs_dly_q) begin
         word_buf_d = spram_d_read;
      end

      case (state_q)
         S_IDLE: begin
            ss_d  = 1'b1;
            sck_d = 1'b0;
            if (start) begin
               busy_d        = 1'b1;
               done_d        = 1'b0;
               sector_d      = 12'd0;
               page_d        = 4'd0;
               rd_addr_d     = 16'd0;
               erase_phase_d = 1'b1;
               frame_on_d    = 1'b0;
               state_d       = S_WREN;
            end
         end

         S_WREN, S_ERASE, S_POLL, S_PROGRAM: begin
            if (!frame_on_q) begin
               // open the frame: SS falls together with the first data bit
               frame_on_d = 1'b1;
               ss_d       = 1'b0;
               sck_d      = 1'b0;
               phase_d    = 1'b0;
               bit_cnt_d  = 12'd0;
               so_d       = header[31];
               tx_d       = header[30:0];
               if (state_q == S_PROGRAM) begin
                  // first word of the page, needed after the 32 header bits
                  cs_d         = 1'b1;
                  spram_addr_d = rd_addr_q;
                  rd_addr_d    = rd_addr_q + 16'd1;
               end
            end else if (!phase_q) begin
               sck_d   = 1'b1;
               phase_d = 1'b1;
            end else begin
               sck_d   = 1'b0;
               phase_d = 1'b0;
               if (frame_last) begin
                  frame_on_d = 1'b0;
                  gap_cnt_d  = 3'd0;
                  state_d    = S_GAP;
                  case (state_q)
                     S_WREN:  ret_d = erase_phase_q ? S_ERASE : S_PROGRAM;
                     S_POLL: begin
                        ret_d = S_WREN;
                        if (erase_phase_q) begin
                           erase_phase_d = 1'b0;
                        end else if (page_q == 4'hF) begin
                           if (sector_q == LAST_SECTOR) begin
                              state_d = S_DONE;
                           end else begin
                              sector_d      = sector_q + 12'd1;
                              page_d        = 4'd0;
                              erase_phase_d = 1'b1;
                           end
                        end else begin
                           page_d = page_q + 4'd1;
                        end
                     end
                     default: ret_d = S_POLL;
                  endcase
               end else begin
                  // status bytes repeat on bit indices 8..15
                  bit_cnt_d = (state_q == S_POLL && bit_cnt_q == POLL_END) ?
                              POLL_WRAP : bit_cnt_q + 12'd1;
                  if (state_q == S_PROGRAM && bit_cnt_q >= HDR_LAST) begin
                     if (data_idx[3:0] == 4'd0) begin
                        so_d  = word_swapped[15];
                        wsr_d = {word_swapped[14:0], 1'b0};
                        // prefetch the following word unless this is the page's last
                        if (data_idx[10:4] != 7'h7F) begin
                           cs_d         = 1'b1;
                           spram_addr_d = rd_addr_q;
                           rd_addr_d    = rd_addr_q + 16'd1;
                        end
                     end else begin
                        so_d  = wsr_q[15];
                        wsr_d = {wsr_q[14:0], 1'b0};
                     end
                  end else begin
                     so_d = tx_q[30];
                     tx_d = {tx_q[29:0], 1'b0};
                  end
               end
            end
         end

         S_GAP: begin
            ss_d      = 1'b1;
            sck_d     = 1'b0;
            so_d      = 1'b0;
            gap_cnt_d = gap_cnt_q + 3'd1;
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ret_q;
            end
         end

         S_DONE: begin
            ss_d    = 1'b1;
            sck_d   = 1'b0;
            so_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset parks the SPI bus idle and abandons any save
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         ret_q         <= S_WREN;
         frame_on_q    <= 1'b0;
         phase_q       <= 1'b0;
         ss_q          <= 1'b1;
         sck_q         <= 1'b0;
         so_q          <= 1'b0;
         tx_q          <= '0;
         bit_cnt_q     <= '0;
         wsr_q         <= '0;
         word_buf_q    <= '0;
         cs_q          <= 1'b0;
         cs_dly_q      <= 1'b0;
         spram_addr_q  <= '0;
         rd_addr_q     <= '0;
         sector_q      <= '0;
         page_q        <= '0;
         erase_phase_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         gap_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         ret_q         <= ret_d;
         frame_on_q    <= frame_on_d;
         phase_q       <= phase_d;
         ss_q          <= ss_d;
         sck_q         <= sck_d;
         so_q          <= so_d;
         tx_q          <= tx_d;
         bit_cnt_q     <= bit_cnt_d;
         wsr_q         <= wsr_d;
         word_buf_q    <= word_buf_d;
         cs_q          <= cs_d;
         cs_dly_q      <= cs_dly_d;
         spram_addr_q  <= spram_addr_d;
         rd_addr_q     <= rd_addr_d;
         sector_q      <= sector_d;
         page_q        <= page_d;
         erase_phase_q <= erase_phase_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         gap_cnt_q     <= gap_cnt_d;
      end
   end

   assign busy       = busy_q;
   assign save_done  = done_q;
   assign spram_addr = spram_addr_q;
   assign spram_cs   = cs_q;
   assign spram_we   = 1'b0;
   assign spi_ss     = ss_q;
   assign spi_sck    = sck_q;
   assign spi_so     = so_q;

endmodule

// File: doc/spram2flash.md
# spram2flash

Save-path counterpart to the boot-time flash loader: copies a region of SPRAM (16-bit words) back into SPI flash so battery-RAM contents survive power-off. On a `start` pulse it erases the target 4 KB sectors, page-programs them from SPRAM word 0 upward, and polls the flash status register after every erase and program. It sits beside the loader on the same SPRAM port and SPI pins; the top level muxes ownership, and the loader is inactive whenever `busy` is high.

## Interface

- `SPI_SAVE_OFFSET`, default 24'h0A0000: flash byte address of the first saved byte; must be 4096-aligned.
- `SPI_SAVE_SIZE`, default 24'h002000: bytes to save; must be a non-zero multiple of 4096.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; accepted only when `busy` is 0.
- `busy` out 1: high from the cycle after an accepted `start` until `save_done` rises.
- `save_done` out 1: high after the full save completes; stays high until the next accepted `start`.
- `spram_addr` out 16: SPRAM word address.
- `spram_cs` out 1: SPRAM read strobe.
- `spram_we` out 1: tied 0; the block never writes SPRAM.
- `spram_d_read` in 16: SPRAM read data, valid 1 cycle after `spram_cs`/`spram_addr`.
- `spi_ss` out 1: flash chip select, active low.
- `spi_so` out 1: MOSI.
- `spi_si` in 1: MISO.
- `spi_sck` out 1: SPI mode-0 clock, idle low.

## Operation

- States: IDLE, WREN, ERASE, POLL, PROGRAM, GAP, DONE.
- IDLE to WREN on accepted `start`; clears `save_done`, zeroes the sector, page and word counters.
- Each command frame:
  - `spi_ss` low for the whole frame.
  - MSB-first bytes.
  - Frame ends with SS high for at least 4 clk (GAP) before the next frame.
- Per 4 KB sector:
  - WREN: send 8'h06.
  - ERASE: send 8'h20 + 24-bit sector address.
  - POLL until idle.
  - Then 16 pages, each: WREN (8'h06), then PROGRAM (8'h02 + 24-bit page address + 256 data bytes), then POLL.
- POLL frame:
  - Send 8'h05, then clock status bytes continuously in the same frame.
  - End the frame after the first status byte with bit0 (WIP) = 0.
  - No timeout; a stuck WIP keeps `busy` high.
- Flash addresses:
  - Sector address = `SPI_SAVE_OFFSET` + 4096·sector.
  - Page address = sector address + 256·page.
  - 24-bit arithmetic, no wrap handling beyond 24 bits.
- PROGRAM data byte order:
  - Each SPRAM word is sent as `word[7:0]` first, then `word[15:8]`, matching the loader's byte packing.
  - Word N of the save maps to flash bytes at offset 2N and 2N+1.
- SPRAM addressing:
  - `spram_addr` runs 0 .. `SPI_SAVE_SIZE`/2−1 and is continuous across pages and sectors.
  - A word is read (`spram_cs` pulsed 1 cycle) at least 2 clk before its first data bit is needed.
  - Each word is latched into a 16-bit shift register.
- After the POLL following the last page of the last sector: go to DONE, raise `spi_ss`, assert `save_done`, drop `busy`, return to IDLE.

## Timing

- SPI bit period is 2 clk.
  - `spi_so` changes on the clk edge where `spi_sck` falls, or in the first cycle after `spi_ss` falls for bit 0.
  - `spi_sck` is high during the second clk of each bit.
  - All SPI outputs are registered.
- `spi_si` is sampled on the clk edge where `spi_sck` falls, i.e. the end of the high half.
- `spi_sck` is low whenever `spi_ss` is high. The last SCK falling edge precedes `spi_ss` rising by at least 1 clk.
- `busy` rises 1 clk after `start`. The first `spi_ss` fall occurs within 2 clk of `busy` rising.
- `start` while `busy`=1 is ignored. `start` coincident with the DONE cycle is ignored.
- Reset values, also forced asynchronously on any reset mid-operation:
  - state IDLE, `spi_ss`=1, `spi_sck`=0, `spi_so`=0.
  - `busy`=0, `save_done`=0, `spram_cs`=0, `spram_addr`=0.
  - A partially programmed page is abandoned; the next `start` restarts from the first sector.
- WREN frame = 8 bits = 16 clk with SS low. ERASE frame = 32 bits. PROGRAM frame = 2080 bits.

## Test plan

- Reset: hold `reset_n`=0, toggle clk, release → `spi_ss`=1, `spi_sck`=0, `busy`=0, `save_done`=0, `spram_we`=0; no SS activity without `start`.
- Full save, `SPI_SAVE_SIZE`=4096, behavioural flash (WIP busy 3 polls) and SPRAM preloaded with word N = 16'hA500^N:
  - Frame sequence: 06; 20 0A0000; 05 polls; then 16× [06; 02 0A0000+256p + 256 bytes; 05 polls].
  - Flash image equals SPRAM byte-swapped per word.
  - `save_done`=1 at end.
- Byte order: word 0 = 16'hBEEF → flash 0x0A0000 = 8'hEF, 0x0A0001 = 8'hBE.
- Status stall: model holds WIP=1 for 1000 status bytes after erase → single continuous POLL frame; no WREN until the first WIP=0 byte, then SS rises.
- `start` pulsed mid-save → ignored; frame sequence and final image identical to an undisturbed run.
- `reset_n` low during the 100th data byte of page 5 → `spi_ss`=1 and `busy`=0 immediately. A new `start` re-issues 06, 20 0A0000 first.
